// File: rtl/aes_pkg.sv
// Shared definitions for the sequential AES key-schedule block:
// key_len encodings, Nk/Nr constants, controller states and the Rcon table.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_AES128  = 2'b00,
    KL_AES192  = 2'b01,
    KL_AES256  = 2'b10,
    KL_INVALID = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXPAND = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  localparam int unsigned WORDS = 60;

  localparam logic [3:0] NK_AES128 = 4'd4;
  localparam logic [3:0] NK_AES192 = 4'd6;
  localparam logic [3:0] NK_AES256 = 4'd8;
  localparam logic [3:0] NR_AES128 = 4'd10;
  localparam logic [3:0] NR_AES192 = 4'd12;
  localparam logic [3:0] NR_AES256 = 4'd14;

  // Element 0 is Rcon[1].
  localparam logic [9:0][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
    8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  function automatic logic [7:0] rcon_of(input logic [3:0] round);
    if (round >= 4'd1 && round <= 4'd10) begin
      rcon_of = RCON[round - 4'd1];
    end else begin
      rcon_of = 8'h00;
    end
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte.
//   in_byte  : byte to substitute
//   out_byte : S-box image of in_byte
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_sched_seq.sv
// Sequential AES key expansion, one schedule word per clock, for 128/192/256-bit keys.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, key_len    : request an expansion; key_len selects AES-128/192/256 (11 rejected)
//   key_in            : cipher key, MSB-aligned (w[0] = key_in[255:224])
//   busy, done, err   : expansion running / completion pulse / rejected-start pulse
//   keys_valid        : stored schedule is complete
//   rk_idx, rk_out    : combinational round-key read port (zero when invalid or out of range)
module aes_key_sched_seq
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  state_e      state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic [2:0]  wrap_q, wrap_d;    // i mod Nk
  logic [3:0]  round_q, round_d;  // i / Nk
  logic [3:0]  nk_q, nk_d;
  logic [3:0]  nr_q, nr_d;
  logic        kv_q, kv_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [WORDS];
  logic [31:0] mem_d [WORDS];

  key_len_e    kl;
  logic        start_ok;
  logic        key_ok;
  logic        last_word;
  logic        wrap_last;
  logic [31:0] w_prev;
  logic [31:0] w_old;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] t_word;
  logic [3:0]  rd_idx;
  logic [5:0]  rd_base;

  assign kl        = key_len_e'(key_len);
  assign start_ok  = start && (state_q != ST_EXPAND);
  assign key_ok    = (kl != KL_INVALID);
  assign last_word = (i_q == {nr_q, 2'b11});
  assign wrap_last = ({1'b0, wrap_q} == (nk_q - 4'd1));

  assign w_prev = mem_q[i_q - 6'd1];
  assign w_old  = mem_q[i_q - {2'b00, nk_q}];
  assign sub_in = (wrap_q == '0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*b +: 8]),
      .out_byte (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    if (wrap_q == '0) begin
      t_word = sub_out ^ {rcon_of(round_q), 24'h000000};
    end else if (nk_q == NK_AES256 && wrap_q == 3'd4) begin
      t_word = sub_out;
    end else begin
      t_word = w_prev;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_ok && key_ok) state_d = ST_EXPAND;
      ST_EXPAND:        if (last_word) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Datapath and counter updates
  always_comb begin
    i_d     = i_q;
    wrap_d  = wrap_q;
    round_d = round_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    kv_d    = kv_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_d   = mem_q;
    if (state_q == ST_EXPAND) begin
      mem_d[i_q] = w_old ^ t_word;
      i_d        = i_q + 6'd1;
      if (wrap_last) begin
        wrap_d  = '0;
        round_d = round_q + 4'd1;
      end else begin
        wrap_d  = wrap_q + 3'd1;
      end
      if (last_word) begin
        done_d = 1'b1;
        kv_d   = 1'b1;
      end
    end else if (start_ok) begin
      if (key_ok) begin
        unique case (kl)
          KL_AES192: begin nk_d = NK_AES192; nr_d = NR_AES192; end
          KL_AES256: begin nk_d = NK_AES256; nr_d = NR_AES256; end
          default:   begin nk_d = NK_AES128; nr_d = NR_AES128; end
        endcase
        for (int unsigned k = 0; k < 8; k++) begin
          if (k < 32'(nk_d)) mem_d[k] = key_in[255 - 32*k -: 32];
        end
        i_d     = {2'b00, nk_d};
        wrap_d  = '0;
        round_d = 4'd1;
        kv_d    = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      wrap_q  <= '0;
      round_q <= '0;
      nk_q    <= '0;
      nr_q    <= '0;
      kv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      wrap_q  <= wrap_d;
      round_q <= round_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      kv_q    <= kv_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Word store is not reset; keys_valid gates the read port instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Outputs
  always_comb begin
    busy       = (state_q == ST_EXPAND);
    done       = done_q;
    err        = err_q;
    keys_valid = kv_q;
    rd_idx     = (rk_idx <= nr_q) ? rk_idx : 4'd0;
    rd_base    = {rd_idx, 2'b00};
    if (kv_q && (rk_idx <= nr_q)) begin
      rk_out = {mem_q[rd_base], mem_q[rd_base + 6'd1],
                mem_q[rd_base + 6'd2], mem_q[rd_base + 6'd3]};
    end else begin
      rk_out = '0;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_seq.sv
module tb_aes_key_sched_seq;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy;
  logic         done;
  logic         err;
  logic         keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  int vectors;
  int miscompares;

  logic [7:0]  sbox_m [256];
  logic [31:0] ew [60];

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes_key_sched_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_len    (key_len),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .keys_valid (keys_valid),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: FIPS-197 key expansion, S-box derived from GF(2^8) inverse + affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] tmp;
    tmp = {b, b} << n;
    return tmp[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    int nr;
    logic [31:0] temp;
    logic [7:0] rc;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) ew[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      temp = ew[i-1];
      if (i % nk == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        temp = sub_word(temp);
      end
      ew[i] = ew[i-nk] ^ temp;
    end
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    k = '0;
    for (int n = 0; n < 8; n++) k = {k[223:0], 32'($urandom())};
    return k;
  endfunction

  task automatic read_rk(input int idx, output logic [127:0] v);
    rk_idx = 4'(idx);
    #1;
    v = rk_out;
  endtask

  task automatic run(input logic [1:0] kl, input logic [255:0] key, input bit spoil, input string tag);
    int nk;
    int nr;
    int cyc;
    int exp_cyc;
    logic [127:0] v;
    nk = 4 + 2 * int'(kl);
    nr = nk + 6;
    exp_cyc = 4 * (nr + 1) - nk;
    model_expand(key, nk);
    @(negedge clk);
    start = 1'b1;
    key_len = kl;
    key_in = key;
    cyc = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b1) break;
      cyc++;
      if (spoil && (cyc == 10 || cyc == exp_cyc)) begin
        start = 1'b1;
        key_len = 2'($urandom_range(0, 3));
        key_in = rand_key();
      end
    end
    chki({tag, "_busy_cycles"}, cyc, exp_cyc);
    chk1({tag, "_done_pulse"}, done, 1'b1);
    chk1({tag, "_keys_valid"}, keys_valid, 1'b1);
    chk1({tag, "_err_quiet"}, err, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk1({tag, "_done_no_repulse"}, done, 1'b0);
      chk1({tag, "_busy_low"}, busy, 1'b0);
    end
    for (int r = 0; r <= nr; r++) begin
      read_rk(r, v);
      chkw($sformatf("%s_rk%0d", tag, r), v, {ew[4*r], ew[4*r+1], ew[4*r+2], ew[4*r+3]});
    end
    for (int r = nr + 1; r < 16; r++) begin
      read_rk(r, v);
      chkw($sformatf("%s_rk%0d_oor", tag, r), v, 128'h0);
    end
  endtask

  task automatic invalid_start(input logic exp_kv, input string tag);
    @(negedge clk);
    start = 1'b1;
    key_len = 2'b11;
    key_in = rand_key();
    @(negedge clk);
    start = 1'b0;
    chk1({tag, "_err_pulse"}, err, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_keys_valid"}, keys_valid, exp_kv);
    @(negedge clk);
    chk1({tag, "_err_once"}, err, 1'b0);
    chk1({tag, "_busy_after"}, busy, 1'b0);
    chk1({tag, "_done_quiet"}, done, 1'b0);
  endtask

  initial begin
    logic [127:0] v;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    key_len = 2'b00;
    key_in = '0;
    rk_idx = 4'd0;
    build_sbox();

    repeat (3) @(negedge clk);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_err", err, 1'b0);
    chk1("reset_keys_valid", keys_valid, 1'b0);
    chkw("reset_rk_out", rk_out, 128'h0);
    rst_n = 1'b1;

    invalid_start(1'b0, "invalid_idle");

    run(2'b00, KEY128, 1'b0, "aes128_kat");
    read_rk(10, v);
    chkw("aes128_kat_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(0, v);
    chkw("aes128_kat_rk0", v, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    invalid_start(1'b1, "invalid_done");
    read_rk(10, v);
    chkw("aes128_after_invalid_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run(2'b01, KEY192, 1'b0, "aes192_kat");
    read_rk(12, v);
    chkw("aes192_kat_rk12", v, 128'ha4970a331a78dc09c418c271e3a41d5d);

    run(2'b10, KEY256, 1'b0, "aes256_kat");
    read_rk(14, v);
    chkw("aes256_kat_rk14", v, 128'h24fc79ccbf0979e9371ac23c6d68de36);

    run(2'b00, KEY128, 1'b1, "aes128_overlap");
    read_rk(10, v);
    chkw("aes128_overlap_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset partway through an expansion
    @(negedge clk);
    start = 1'b1;
    key_len = 2'b00;
    key_in = KEY128;
    rk_idx = 4'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk1("midreset_busy_before", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("midreset_busy", busy, 1'b0);
    chk1("midreset_keys_valid", keys_valid, 1'b0);
    chk1("midreset_done", done, 1'b0);
    chkw("midreset_rk_out", rk_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(2'b00, KEY128, 1'b0, "aes128_after_reset");
    read_rk(10, v);
    chkw("aes128_after_reset_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int n = 0; n < 3; n++) begin
      run(2'(n), rand_key(), 1'b0, $sformatf("rand_kl%0d", n));
    end
    run(2'($urandom_range(0, 2)), rand_key(), 1'b1, "rand_overlap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_seq.md
AES_KEY_SCHED_SEQ -- requirements
Module: aes_key_sched_seq

Interface
REQ-001 SHALL have parameter NONE; key length is selected at run time by key_len.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request a new expansion.
REQ-005 SHALL have port key_len  input  2  sampled with start: 00=AES-128 (Nk=4, Nr=10), 01=AES-192 (Nk=6, Nr=12), 10=AES-256 (Nk=8, Nr=14), 11=invalid.
REQ-006 SHALL have port key_in  input  256  cipher key, MSB-aligned: w[0]=key_in[255:224]; unused LSBs ignored.
REQ-007 SHALL have port busy  output  1  expansion in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the schedule completes.
REQ-009 SHALL have port err  output  1  one-cycle pulse when a start is rejected for key_len=11.
REQ-010 SHALL have port keys_valid  output  1  the stored schedule is complete and readable.
REQ-011 SHALL have port rk_idx  input  4  round-key index 0..Nr.
REQ-012 SHALL have port rk_out  output  128  round key {w[4*rk_idx], .., w[4*rk_idx+3]}, combinational from rk_idx.

Function
REQ-013 SHALL hold a 60 x 32-bit word store and have states IDLE, EXPAND and DONE.
REQ-014 SHALL accept start only when busy=0 (IDLE or DONE); a start while busy SHALL be ignored.
REQ-015 An accepted start with valid key_len SHALL, on that edge, write w[0..Nk-1] from key_in, latch Nk/Nr, clear keys_valid, set i=Nk and enter EXPAND.
REQ-016 An accepted start with key_len=11 SHALL pulse err the next cycle, leave the state and store unchanged, and leave keys_valid unchanged.
REQ-017 EXPAND SHALL write exactly one word per cycle: w[i] = w[i-Nk] ^ t, where t is one of the following.
- SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk],24'h0} when i mod Nk = 0.
- SubWord(w[i-1]) when Nk=8 and i mod Nk = 4.
- w[i-1] otherwise.
REQ-018 i mod Nk and i/Nk SHALL be tracked with a wrap counter and a round counter; no divider SHALL be used.
REQ-019 Rcon SHALL follow 01,02,04,08,10,20,40,80,1b,36.
REQ-020 EXPAND SHALL last 4(Nr+1)-Nk cycles: 40, 46 and 52 for AES-128, -192 and -256, with busy=1 throughout.
REQ-021 After the edge that writes the last word (i=4Nr+3), the block SHALL enter DONE.
- done=1 for exactly one cycle.
- keys_valid=1.
- busy=0.
REQ-022 DONE SHALL persist until the next accepted start; done SHALL not re-pulse.
REQ-023 rk_out SHALL be 128'h0 when keys_valid=0 or rk_idx>Nr.
REQ-024 A start in the same cycle as the final EXPAND word SHALL be ignored, because busy=1.

Reset
REQ-025 rst_n low SHALL asynchronously force the following.
- state=IDLE.
- busy=0, done=0, err=0, keys_valid=0.
- Counters=0.
REQ-026 Reset SHALL not clear the word store; rk_out SHALL read 0 via keys_valid=0.
REQ-027 Reset mid-EXPAND SHALL abort the expansion; the next start SHALL restart it from w[0].

Structure
REQ-028 Package aes_pkg SHALL hold the following.
- key_len encodings.
- Nk/Nr constants.
- The state enum.
- The Rcon table.
REQ-029 SHALL instantiate sub-module aes_sbox, a combinational byte S-box, four times for SubWord; no other sub-modules.

Verification
REQ-030 AES-128: key 2b7e1516_28aed2a6_abf71588_09cf4f3c.
- busy SHALL be high for 40 cycles, then done SHALL pulse.
- rk_idx=10 SHALL give d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
- rk_idx=0 SHALL return the key.
REQ-031 AES-192: key 00010203..14151617.
- busy SHALL be high for 46 cycles.
- rk_idx=12 SHALL give a4970a33_1a78dc09_c418c271_e3a41d5d.
REQ-032 AES-256: key 00010203..1c1d1e1f.
- busy SHALL be high for 52 cycles.
- rk_idx=14 SHALL give 24fc79cc_bf0979e9_371ac23c_6d68de36.
REQ-033 Invalid and overlapping starts:
- key_len=11 -> err pulses once and busy stays 0.
- start asserted during EXPAND -> ignored; the AES-128 result is unchanged.
REQ-034 Reset mid-operation: rst_n asserted at EXPAND cycle 20 -> busy=0, keys_valid=0 and rk_out=0 immediately; a following start completes the AES-128 vector correctly.
REQ-035 Out-of-range read: after the AES-128 run, rk_idx=11..15 -> rk_out=0.
